// File: rtl/layer_sequencer_if.sv
// Game-flow bus between the frame timing/event sources and the layer sequencer.
// Inputs are sampled on the pixel clock. Outputs are registered. There is no backpressure.
interface layer_sequencer_if;
    logic       startOfFrame;
    logic       keyStart;
    logic       collision;
    logic       fuelEmpty;
    logic       finishReached;
    logic [4:0] layerEn;
    logic [1:0] screenSel;
    logic       gameRun;
    logic [2:0] livesLeft;

    modport master (
        output startOfFrame, keyStart, collision, fuelEmpty, finishReached,
        input  layerEn, screenSel, gameRun, livesLeft
    );

    modport slave (
        input  startOfFrame, keyStart, collision, fuelEmpty, finishReached,
        output layerEn, screenSel, gameRun, livesLeft
    );
endinterface

// File: rtl/layer_sequencer.sv
// Game-state FSM (START/PLAY/CRASH/OVER/WIN) that drives layer enables. It changes state only at
// startOfFrame, and its outputs follow one cycle after each transition. It has no backpressure.
module layer_sequencer #(
    parameter int CRASH_FRAMES = 60,
    parameter int BLINK_FRAMES = 8,
    parameter int LIVES        = 3
) (
    input  logic               clk,
    input  logic               reset,
    layer_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {S_START, S_PLAY, S_CRASH, S_OVER, S_WIN} state_t;

    state_t     r_state, w_state_nx;
    logic       r_key_d, r_key_pend;
    logic       r_coll_pend, r_fin_pend, r_fuel_pend;
    logic [2:0] r_lives;
    logic [7:0] r_frame_cnt, r_blink_cnt;
    logic       r_blink_on;
    logic [4:0] r_layer_en, w_layer_en;
    logic [1:0] r_screen_sel, w_screen_sel;
    logic       r_game_run, w_game_run;

    logic w_key_rise, w_key, w_coll, w_fin, w_fuel, w_crash_done, w_trans;

    assign w_key_rise   = bus.keyStart & ~r_key_d;
    assign w_key        = r_key_pend | w_key_rise;
    assign w_coll       = r_coll_pend | bus.collision;
    assign w_fin        = r_fin_pend  | bus.finishReached;
    assign w_fuel       = r_fuel_pend | bus.fuelEmpty;
    assign w_crash_done = (r_frame_cnt == 8'(CRASH_FRAMES - 1));
    assign w_trans      = (w_state_nx != r_state);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_START;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        if (bus.startOfFrame) begin
            case (r_state)
                S_START: if (w_key) w_state_nx = S_PLAY;
                S_PLAY: begin
                    if (w_fin)       w_state_nx = S_WIN;
                    else if (w_fuel) w_state_nx = S_OVER;
                    else if (w_coll) w_state_nx = S_CRASH;
                end
                S_CRASH: if (w_crash_done) w_state_nx = (r_lives != 3'd0) ? S_PLAY : S_OVER;
                S_OVER, S_WIN: if (w_key) w_state_nx = S_START;
                default: w_state_nx = S_START;
            endcase
        end
    end

    always_comb begin
        w_layer_en   = 5'b10011;
        w_screen_sel = r_screen_sel;
        w_game_run   = 1'b0;
        case (r_state)
            S_START: w_screen_sel = 2'd0;
            S_PLAY: begin
                w_layer_en = 5'b01111;
                w_game_run = 1'b1;
            end
            S_CRASH: w_layer_en = {1'b0, r_blink_on, 3'b111};
            S_OVER:  w_screen_sel = 2'd2;
            S_WIN:   w_screen_sel = 2'd1;
            default: w_screen_sel = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_layer_en   <= 5'b10011;
            r_screen_sel <= 2'd0;
            r_game_run   <= 1'b0;
        end else begin
            r_layer_en   <= w_layer_en;
            r_screen_sel <= w_screen_sel;
            r_game_run   <= w_game_run;
        end
    end

    // The edge register resets to 1, so a key held high through reset release does not count as a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_d     <= 1'b1;
            r_key_pend  <= 1'b0;
            r_coll_pend <= 1'b0;
            r_fin_pend  <= 1'b0;
            r_fuel_pend <= 1'b0;
            r_lives     <= 3'(LIVES);
            r_frame_cnt <= 8'd0;
            r_blink_cnt <= 8'd0;
            r_blink_on  <= 1'b0;
        end else begin
            r_key_d <= bus.keyStart;
            if (bus.startOfFrame) r_key_pend <= 1'b0;
            else if (w_key_rise)  r_key_pend <= 1'b1;

            if (w_trans) begin
                r_coll_pend <= 1'b0;
                r_fin_pend  <= 1'b0;
                r_fuel_pend <= 1'b0;
            end else if (r_state == S_PLAY) begin
                r_coll_pend <= w_coll;
                r_fin_pend  <= w_fin;
                r_fuel_pend <= w_fuel;
            end

            if (w_trans && w_state_nx == S_CRASH)
                r_lives <= (r_lives == 3'd0) ? 3'd0 : r_lives - 3'd1;
            else if (w_trans && w_state_nx == S_START)
                r_lives <= 3'(LIVES);

            if (w_trans && w_state_nx == S_CRASH) begin
                r_frame_cnt <= 8'd0;
                r_blink_cnt <= 8'd0;
                r_blink_on  <= 1'b0;
            end else if (r_state == S_CRASH && bus.startOfFrame && !w_trans) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
                if (r_blink_cnt == 8'(BLINK_FRAMES - 1)) begin
                    r_blink_cnt <= 8'd0;
                    r_blink_on  <= ~r_blink_on;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 8'd1;
                end
            end
        end
    end

    assign bus.layerEn   = r_layer_en;
    assign bus.screenSel = r_screen_sel;
    assign bus.gameRun   = r_game_run;
    assign bus.livesLeft = r_lives;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with CRASH_FRAMES=4, BLINK_FRAMES=1, LIVES=2.
module tb_layer_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    layer_sequencer_if u_if();

    layer_sequencer #(.CRASH_FRAMES(4), .BLINK_FRAMES(1), .LIVES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame: the pulse edge, one cycle for the outputs to follow, then two idle cycles.
    task automatic frame();
        u_if.startOfFrame = 1'b1;
        tick();
        u_if.startOfFrame = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic press_key();
        u_if.keyStart = 1'b0;
        tick();
        u_if.keyStart = 1'b1;
        tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        u_if.startOfFrame = 1'b0;
        u_if.keyStart = 1'b0;
        u_if.collision = 1'b0;
        u_if.fuelEmpty = 1'b0;
        u_if.finishReached = 1'b0;
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_layer", 8'(u_if.layerEn), 8'h13);
        chk("rst_sel",   8'(u_if.screenSel), 8'd0);
        chk("rst_run",   8'(u_if.gameRun), 8'd0);
        chk("rst_lives", 8'(u_if.livesLeft), 8'd2);

        // Start key pressed mid-frame; the transition waits for startOfFrame.
        u_if.keyStart = 1'b1;
        tick(); tick();
        chk("start_midframe", 8'(u_if.layerEn), 8'h13);
        u_if.startOfFrame = 1'b1;
        tick();
        chk("play_latency", 8'(u_if.layerEn), 8'h13);
        u_if.startOfFrame = 1'b0;
        tick();
        chk("play_layer", 8'(u_if.layerEn), 8'h0F);
        chk("play_run",   8'(u_if.gameRun), 8'd1);

        // First crash: the player-layer bit blinks 0,1,0,1, then play resumes.
        u_if.collision = 1'b1; tick(); u_if.collision = 1'b0; tick();
        chk("coll_midframe", 8'(u_if.layerEn), 8'h0F);
        frame();
        chk("crash_lives", 8'(u_if.livesLeft), 8'd1);
        chk("crash_run",   8'(u_if.gameRun), 8'd0);
        chk("crash_f0",    8'(u_if.layerEn), 8'h07);
        frame();
        chk("crash_f1",    8'(u_if.layerEn), 8'h0F);
        chk("crash_f1_run", 8'(u_if.gameRun), 8'd0);
        frame();
        chk("crash_f2",    8'(u_if.layerEn), 8'h07);
        frame();
        chk("crash_f3",    8'(u_if.layerEn), 8'h0F);
        frame();
        chk("resume_run",  8'(u_if.gameRun), 8'd1);
        chk("resume_layer", 8'(u_if.layerEn), 8'h0F);

        // Second crash with the last life leads to game over.
        u_if.collision = 1'b1; tick(); u_if.collision = 1'b0;
        frame();
        chk("crash2_lives", 8'(u_if.livesLeft), 8'd0);
        frame(); frame(); frame();
        chk("crash2_f3", 8'(u_if.layerEn), 8'h0F);
        frame();
        chk("over_layer", 8'(u_if.layerEn), 8'h13);
        chk("over_sel",   8'(u_if.screenSel), 8'd2);
        chk("over_lives", 8'(u_if.livesLeft), 8'd0);
        press_key();
        frame();
        chk("restart_sel",   8'(u_if.screenSel), 8'd0);
        chk("restart_lives", 8'(u_if.livesLeft), 8'd2);

        // Collision and finish in the same frame: finish has priority.
        press_key();
        frame();
        chk("play2_run", 8'(u_if.gameRun), 8'd1);
        u_if.collision = 1'b1; tick(); u_if.collision = 1'b0; tick();
        u_if.finishReached = 1'b1; tick(); u_if.finishReached = 1'b0;
        frame();
        chk("win_layer", 8'(u_if.layerEn), 8'h13);
        chk("win_sel",   8'(u_if.screenSel), 8'd1);
        chk("win_lives", 8'(u_if.livesLeft), 8'd2);

        // Reset in the middle of a crash while the key is held high.
        press_key(); frame();
        chk("win_to_start", 8'(u_if.screenSel), 8'd0);
        press_key(); frame();
        u_if.collision = 1'b1; tick(); u_if.collision = 1'b0;
        frame();
        chk("crash3_lives", 8'(u_if.livesLeft), 8'd1);
        frame();
        chk("crash3_f1", 8'(u_if.layerEn), 8'h0F);
        u_if.startOfFrame = 1'b1;
        tick();
        u_if.startOfFrame = 1'b0;
        tick();
        chk("crash3_f2", 8'(u_if.layerEn), 8'h07);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_layer", 8'(u_if.layerEn), 8'h13);
        chk("midrst_lives", 8'(u_if.livesLeft), 8'd2);
        chk("midrst_run",   8'(u_if.gameRun), 8'd0);
        chk("midrst_sel",   8'(u_if.screenSel), 8'd0);
        for (int i = 0; i < 5; i++) frame();
        chk("held_key_layer", 8'(u_if.layerEn), 8'h13);
        chk("held_key_run",   8'(u_if.gameRun), 8'd0);

        // An empty fuel tank ends the game with lives left.
        press_key(); frame();
        chk("play3_run", 8'(u_if.gameRun), 8'd1);
        u_if.fuelEmpty = 1'b1; tick(); u_if.fuelEmpty = 1'b0; tick();
        frame();
        chk("fuel_sel",   8'(u_if.screenSel), 8'd2);
        chk("fuel_layer", 8'(u_if.layerEn), 8'h13);
        chk("fuel_lives", 8'(u_if.livesLeft), 8'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
